// File: rtl/arm_regfile_pkg.sv
// Shared defaults, word types and the PC-index helper for the arm_regfile slice.
// Optional same-edge read bypass is enabled with the ARM_REGFILE_BYPASS_EN macro.
package arm_regfile_pkg;

  localparam int DEFAULT_DATA_W      = 32;
  localparam int DEFAULT_NUM_REGS    = 16;
  localparam int DEFAULT_ADDR_W      = $clog2(DEFAULT_NUM_REGS);
  localparam int DEFAULT_PC_STEP     = 4;
  localparam int DEFAULT_PC_READ_OFS = 8;

  typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEFAULT_DATA_W-1:0] reg_data_t;

  // The PC always lives at the highest register index.
  function automatic int pc_idx(input int num_regs);
    return num_regs - 1;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: address decode, PC read offset and output register.
// With ARM_REGFILE_BYPASS_EN defined it reads the post-write (next-state) view.
module regfile_read_port
  import arm_regfile_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int NUM_REGS    = DEFAULT_NUM_REGS,
  parameter int ADDR_W      = $clog2(NUM_REGS),
  parameter int PC_READ_OFS = DEFAULT_PC_READ_OFS
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [ADDR_W-1:0]                rd_addr,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_q,
`ifdef ARM_REGFILE_BYPASS_EN
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_d,
`endif
  output logic [DATA_W-1:0]                rd_data
);

  localparam int                PC_IDX     = pc_idx(NUM_REGS);
  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] PC_ADDR    = ADDR_W'(PC_IDX);

  logic [NUM_REGS-1:0][DATA_W-1:0] src;
  logic [DATA_W-1:0]               rd_next;

`ifdef ARM_REGFILE_BYPASS_EN
  assign src = regs_d;
`else
  assign src = regs_q;
`endif

  // Addresses past the last register (non-power-of-two NUM_REGS) read as zero.
  always_comb begin
    rd_next = '0;
    if ({1'b0, rd_addr} < NUM_REGS_W) begin
      rd_next = src[rd_addr];
      if (rd_addr == PC_ADDR) begin
        rd_next = rd_next + DATA_W'(PC_READ_OFS);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_next;
    end
  end

endmodule

// File: rtl/arm_regfile.sv
// ARM-style register file: general registers plus PC at the top index, two
// registered read ports, two write ports. Bypass selected by ARM_REGFILE_BYPASS_EN.
module arm_regfile
  import arm_regfile_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int NUM_REGS    = DEFAULT_NUM_REGS,
  parameter int ADDR_W      = $clog2(NUM_REGS),
  parameter int PC_STEP     = DEFAULT_PC_STEP,
  parameter int PC_READ_OFS = DEFAULT_PC_READ_OFS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              pc_load,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              pc_step,
  output logic [DATA_W-1:0] pc_out
);

  localparam int                PC_IDX  = pc_idx(NUM_REGS);
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

  // Index PC_IDX of both views holds the PC; the rest are general registers.
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;

  logic wr0_pc;
  logic wr1_pc;

  assign wr0_pc = wr0_en && (wr0_addr == PC_ADDR);
  assign wr1_pc = wr1_en && (wr1_addr == PC_ADDR);

  // NOTE: combinational next-state uses blocking '=' with a full default first,
  // so later statements override earlier ones and no latch is inferred.
  always_comb begin
    regs_d = regs_q;

    // wr1 is applied first so a same-address wr0 overrides it.
    for (int i = 0; i < PC_IDX; i++) begin
      if (wr1_en && (wr1_addr == ADDR_W'(i))) begin
        regs_d[i] = wr1_data;
      end
      if (wr0_en && (wr0_addr == ADDR_W'(i))) begin
        regs_d[i] = wr0_data;
      end
    end

    // PC priority: branch load, then explicit writes, then sequential step.
    if (pc_load) begin
      regs_d[PC_IDX] = pc_in;
    end else if (wr0_pc) begin
      regs_d[PC_IDX] = wr0_data;
    end else if (wr1_pc) begin
      regs_d[PC_IDX] = wr1_data;
    end else if (pc_step) begin
      regs_d[PC_IDX] = regs_q[PC_IDX] + DATA_W'(PC_STEP);
    end
  end

  // NOTE: the whole array is reset because every register must read zero after
  // reset; sequential state is updated with non-blocking '<=' only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign pc_out = regs_q[PC_IDX];

  regfile_read_port #(
    .DATA_W      (DATA_W),
    .NUM_REGS    (NUM_REGS),
    .ADDR_W      (ADDR_W),
    .PC_READ_OFS (PC_READ_OFS)
  ) u_read_a (
    .clk     (clk),
    .reset   (reset),
    .rd_addr (rd_addr_a),
    .regs_q  (regs_q),
`ifdef ARM_REGFILE_BYPASS_EN
    .regs_d  (regs_d),
`endif
    .rd_data (rd_data_a)
  );

  regfile_read_port #(
    .DATA_W      (DATA_W),
    .NUM_REGS    (NUM_REGS),
    .ADDR_W      (ADDR_W),
    .PC_READ_OFS (PC_READ_OFS)
  ) u_read_b (
    .clk     (clk),
    .reset   (reset),
    .rd_addr (rd_addr_b),
    .regs_q  (regs_q),
`ifdef ARM_REGFILE_BYPASS_EN
    .regs_d  (regs_d),
`endif
    .rd_data (rd_data_b)
  );

endmodule

// File: doc/arm_regfile.md
# arm_regfile

Parametrised ARM-style general-purpose register file: NUM_REGS registers of DATA_W bits, two registered read ports, two write ports, and a dedicated program-counter register at the top index with load/step control. It sits in the CPU decode/execute stage, feeds ALU operands, accepts ALU and load/writeback results, and replaces per-register single-register instances.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 16, register count; index NUM_REGS-1 is the PC
- ADDR_W, $clog2(NUM_REGS), register address width
- PC_STEP, 4, PC increment per pc_step
- PC_READ_OFS, 8, offset added when a read port addresses the PC

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset
- rd_addr_a  in  ADDR_W  read port A address
- rd_addr_b  in  ADDR_W  read port B address
- rd_data_a  out  DATA_W  registered read data A
- rd_data_b  out  DATA_W  registered read data B
- wr0_en  in  1  write port 0 enable (ALU result)
- wr0_addr  in  ADDR_W  write port 0 address
- wr0_data  in  DATA_W  write port 0 data
- wr1_en  in  1  write port 1 enable (load/base writeback)
- wr1_addr  in  ADDR_W  write port 1 address
- wr1_data  in  DATA_W  write port 1 data
- pc_load  in  1  load PC from pc_in (branch)
- pc_in  in  DATA_W  branch target
- pc_step  in  1  advance PC by PC_STEP
- pc_out  out  DATA_W  current PC value (unoffset)

## Operation
- Reset (reset low, any time, asynchronous): all registers, PC, rd_data_a, rd_data_b = 0; pending writes discarded. Release resumes normal operation next rising edge.
- Read: on each edge, rd_data_x <= regs[rd_addr_x]; if rd_addr_x == NUM_REGS-1, value is PC + PC_READ_OFS (modulo 2^DATA_W).
- Write, general registers (index < NUM_REGS-1): wr0 and wr1 update on the edge. Both ports to same address: wr0 wins, wr1 dropped.
- PC update priority, highest first: pc_load (PC <= pc_in); wr0_en to PC index; wr1_en to PC index; pc_step (PC <= PC + PC_STEP, wraps at 2^DATA_W); else hold.
- PC write data is stored as-is; no alignment masking.
- rd_addr beyond NUM_REGS-1 (non-power-of-two NUM_REGS): rd_data = 0; writes ignored.

## Timing
- Read latency: 1 cycle; address at edge N, data valid after edge N.
- Write latency: 1 cycle; value readable from an address presented at edge N+1.
- Same-edge write and read of one address: see Configuration.
- pc_out reflects PC register directly (0 cycles after the updating edge).
- No stalls, no handshake; every port accepted every cycle.

## Configuration
- ARM_REGFILE_BYPASS_EN defined: same-edge read of an address being written returns the new data (winning write per priority above, PC read still gets + PC_READ_OFS on the new PC value, including pc_load/pc_step results).
- Undefined: same-edge read returns the pre-write value; new value visible one cycle later.

## Structure
- Package arm_regfile_pkg: default DATA_W, NUM_REGS, PC_STEP, PC_READ_OFS constants; function pc_idx(NUM_REGS); typedef for register address and data words.
- Sub-module regfile_read_port: address mux, PC offset, optional bypass, output register; instantiated twice (A, B).
- Top holds register array, write arbitration, PC next-state logic.

## Test plan
- Reset mid-run with regs loaded -> rd_data_a/b and pc_out = 0 immediately, all reads 0 afterwards.
- wr0 r3=0xDEADBEEF, next edge read A=r3 -> rd_data_a=0xDEADBEEF one cycle later; read B=r4 -> 0.
- wr0 r5=0x11, wr1 r5=0x22 same edge -> r5 reads 0x11.
- pc_step x3 from reset -> pc_out=0x0C; read A=r15 -> 0x14; pc_load 0x100 with pc_step and wr0 to r15 same edge -> pc_out=0x100.
- PC=0xFFFFFFFC, pc_step -> pc_out=0x0; read r15 -> 0x8.
- Write r7=0x55 and read r7 same edge -> 0x55 with ARM_REGFILE_BYPASS_EN, old value without, 0x55 one cycle later.
